// File: rtl/memory_unit_if.sv
// +-------------------------------------------------------------------+
// | memory_unit_if : CPU control, loader and output-port signal group |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

interface memory_unit_if;
  logic [7:0] addr_bus;
  logic       c_ri;
  logic       c_ro;
  logic       mem_clk;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       cpu_reset;
  logic [7:0] out_data;
  logic       out_strobe;

  modport master (
    output addr_bus, c_ri, c_ro, mem_clk, load_valid, load_data, load_last,
    input  load_ready, cpu_reset, out_data, out_strobe
  );

  modport slave (
    input  addr_bus, c_ri, c_ro, mem_clk, load_valid, load_data, load_last,
    output load_ready, cpu_reset, out_data, out_strobe
  );
endinterface

`default_nettype wire

// File: rtl/memory_unit.sv
// +-------------------------------------------------------------------+
// | memory_unit : 256x8 RAM with boot loader, CPU bus port, out port  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module memory_unit #(
  parameter int         LOAD_ENABLE    = 1,
  parameter logic [7:0] OUT_ADDR       = 8'hFF,
  parameter int         RELEASE_CYCLES = 3
) (
  input  wire logic    clk,
  input  wire logic    reset,
  memory_unit_if.slave mif,
  // The shared data bus stays a plain port so its tristate resolves on the top-level net.
  inout  wire [7:0]    bus
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam state_t RESET_STATE = (LOAD_ENABLE != 0) ? LOAD : RUN;
  localparam logic   RESET_CPU   = (LOAD_ENABLE != 0);
  localparam int     CW          = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CW-1:0] REL_LAST =
    (RELEASE_CYCLES > 1) ? CW'(RELEASE_CYCLES - 1) : '0;

  state_t        state;
  state_t        next_state;
  logic [7:0]    ptr;
  logic [CW-1:0] rel_cnt;
  logic          mem_clk_q;
  logic [7:0]    out_data_q;
  logic          out_strobe_q;
  logic          cpu_reset_q;
  logic [7:0]    mem [256];

  logic          load_rdy;
  logic          load_accept;
  logic          run_write;
  logic          write_out;
  logic          write_ram;
  logic          rd_en;
  logic [7:0]    rd_data;

  assign load_rdy    = (state == LOAD) && !reset;
  assign load_accept = load_rdy && mif.load_valid;

  // One write per mem_clk pulse: only the cycle where the level first rises counts.
  assign run_write = (state == RUN) && mif.mem_clk && !mem_clk_q && mif.c_ri;
  assign write_out = run_write && (mif.addr_bus == OUT_ADDR);
  assign write_ram = run_write && (mif.addr_bus != OUT_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD: begin
        if (load_accept && (mif.load_last || (ptr == 8'hFF))) begin
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (rel_cnt == REL_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        next_state = RUN;
      end
      default: begin
        next_state = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= 8'h00;
      rel_cnt      <= '0;
      mem_clk_q    <= 1'b0;
      out_data_q   <= 8'h00;
      out_strobe_q <= 1'b0;
      cpu_reset_q  <= RESET_CPU;
    end else begin
      if (load_accept) begin
        ptr <= ptr + 8'd1;
      end
      rel_cnt      <= (state == RELEASE) ? rel_cnt + 1'b1 : '0;
      mem_clk_q    <= mif.mem_clk;
      out_strobe_q <= write_out;
      if (write_out) begin
        out_data_q <= bus;
      end
      // Registered so the CPU leaves reset one clock after RUN is entered.
      cpu_reset_q  <= (state != RUN);
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem[ptr] <= mif.load_data;
    end else if (write_ram) begin
      mem[mif.addr_bus] <= bus;
    end
  end

  assign rd_en   = (state == RUN) && mif.c_ro && !mif.c_ri && !reset;
  assign rd_data = (mif.addr_bus == OUT_ADDR) ? out_data_q : mem[mif.addr_bus];
  assign bus     = rd_en ? rd_data : 8'hzz;

  assign mif.load_ready = load_rdy;
  assign mif.cpu_reset  = cpu_reset_q;
  assign mif.out_data   = out_data_q;
  assign mif.out_strobe = out_strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_unit.sv
// +-------------------------------------------------------------------+
// | tb_memory_unit : directed + random bench with array reference model |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_memory_unit;
  localparam logic [7:0] OUT_A = 8'hFF;
  localparam int         REL   = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  wire  [7:0] bus;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_val = 8'h00;

  assign bus = tb_drv ? tb_val : 8'hzz;

  memory_unit_if mif ();

  memory_unit #(
    .LOAD_ENABLE   (1),
    .OUT_ADDR      (OUT_A),
    .RELEASE_CYCLES(REL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mif  (mif),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] ref_mem [256];
  bit         known   [256];
  logic [7:0] ref_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_cpu_reset", 32'(mif.cpu_reset), 32'd1);
    check("reset_load_ready", 32'(mif.load_ready), 32'd0);
    check("reset_out_strobe", 32'(mif.out_strobe), 32'd0);
    check("reset_out_data", 32'(mif.out_data), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    ref_out = 8'h00;
    #1;
    check("post_reset_load_ready", 32'(mif.load_ready), 32'd1);
    check("post_reset_cpu_reset", 32'(mif.cpu_reset), 32'd1);
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    mif.load_valid = 1'b1;
    mif.load_data  = d;
    mif.load_last  = last;
    #1;
    check("load_ready_before_accept", 32'(mif.load_ready), 32'd1);
    tick();
    mif.load_valid = 1'b0;
    mif.load_last  = 1'b0;
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    check({tag, "_ready_low_in_release"}, 32'(mif.load_ready), 32'd0);
    check({tag, "_cpu_reset_in_release"}, 32'(mif.cpu_reset), 32'd1);
    while (mif.cpu_reset === 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_release_cycles"}, 32'(n), 32'(REL + 1));
  endtask

  // Bus value changes after the first edge so a repeated write would be visible.
  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input int hold,
                           input logic also_ro);
    int strobes = 0;
    mif.addr_bus = a;
    mif.c_ri     = 1'b1;
    mif.c_ro     = also_ro;
    mif.mem_clk  = 1'b1;
    tb_drv       = 1'b1;
    tb_val       = d;
    if (also_ro) begin
      #1;
      check("bus_undriven_ri_and_ro", 32'(bus), 32'(d));
    end
    tick();
    if (mif.out_strobe) strobes++;
    for (int i = 1; i < hold; i++) begin
      tb_val = ~d;
      tick();
      if (mif.out_strobe) strobes++;
    end
    mif.mem_clk = 1'b0;
    mif.c_ri    = 1'b0;
    mif.c_ro    = 1'b0;
    tb_drv      = 1'b0;
    tick();
    if (mif.out_strobe) strobes++;
    if (a == OUT_A) begin
      ref_out = d;
      check("out_data_after_write", 32'(mif.out_data), 32'(ref_out));
    end else begin
      ref_mem[a] = d;
      known[a]   = 1'b1;
    end
    check($sformatf("out_strobe_pulses_%02h", a), 32'(strobes), (a == OUT_A) ? 32'd1 : 32'd0);
  endtask

  task automatic cpu_read(input logic [7:0] a);
    mif.addr_bus = a;
    mif.c_ri     = 1'b0;
    mif.c_ro     = 1'b1;
    tb_drv       = 1'b0;
    #1;
    check($sformatf("read_%02h", a), 32'(bus), (a == OUT_A) ? 32'(ref_out) : 32'(ref_mem[a]));
    mif.c_ro = 1'b0;
    #1;
  endtask

  // The bench drives zero; a nonzero cell driven by the DUT would corrupt the net.
  task automatic hiz_probe(input string tag, input logic [7:0] a);
    mif.addr_bus = a;
    mif.c_ri     = 1'b0;
    mif.c_ro     = 1'b1;
    tb_drv       = 1'b1;
    tb_val       = 8'h00;
    #1;
    check(tag, 32'(bus), 32'd0);
    tb_drv   = 1'b0;
    mif.c_ro = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] early  [5];
    logic [7:0] stream [256];
    logic [7:0] a;

    mif.addr_bus   = 8'h00;
    mif.c_ri       = 1'b0;
    mif.c_ro       = 1'b0;
    mif.mem_clk    = 1'b0;
    mif.load_valid = 1'b0;
    mif.load_data  = 8'h00;
    mif.load_last  = 1'b0;
    ref_out        = 8'h00;
    for (int i = 0; i < 256; i++) begin
      known[i]   = 1'b0;
      ref_mem[i] = 8'h00;
    end
    tick();
    do_reset();

    // Partial load interrupted by reset; cells 3 and 4 must survive the restart.
    for (int i = 0; i < 5; i++) begin
      early[i] = 8'($urandom_range(1, 255));
      load_byte(early[i], 1'b0);
    end
    ref_mem[3] = early[3];
    known[3]   = 1'b1;
    ref_mem[4] = early[4];
    known[4]   = 1'b1;
    do_reset();

    load_byte(8'h10, 1'b0);
    load_byte(8'h20, 1'b0);
    load_byte(8'h30, 1'b1);
    ref_mem[0] = 8'h10;
    ref_mem[1] = 8'h20;
    ref_mem[2] = 8'h30;
    known[0]   = 1'b1;
    known[1]   = 1'b1;
    known[2]   = 1'b1;
    wait_release("short_load");
    for (int i = 0; i < 5; i++) cpu_read(8'(i));

    cpu_write(8'h05, 8'hA5, 3, 1'b0);
    cpu_read(8'h05);
    cpu_write(OUT_A, 8'h42, 2, 1'b0);
    cpu_read(OUT_A);
    cpu_write(8'h01, ~ref_mem[1], 1, 1'b1);
    cpu_read(8'h01);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) == 0) ? OUT_A : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1 || !(known[a] || a == OUT_A)) begin
        cpu_write(a, 8'($urandom_range(0, 255)), int'($urandom_range(1, 3)),
                  $urandom_range(0, 3) == 0);
      end else begin
        cpu_read(a);
      end
    end
    cpu_write(8'h00, 8'h5A, 1, 1'b0);

    do_reset();
    hiz_probe("hiz_in_load", 8'h00);

    for (int i = 0; i < 256; i++) begin
      stream[i] = 8'($urandom_range(1, 255));
      load_byte(stream[i], 1'b0);
      ref_mem[i] = stream[i];
      known[i]   = 1'b1;
    end
    // A 257th byte is offered but must not be taken.
    mif.load_valid = 1'b1;
    mif.load_data  = 8'hE7;
    hiz_probe("hiz_in_release", 8'h00);
    wait_release("full_load");
    mif.load_valid = 1'b0;
    for (int i = 0; i < 255; i++) cpu_read(8'(i));

    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        cpu_write(a, 8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 1'b0);
      end
      cpu_read(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Parameters
REQ-001 SHALL have parameter LOAD_ENABLE, default 1, meaning 1 = boot-load RAM from the load port after reset and 0 = enter RUN directly.
REQ-002 SHALL have parameter OUT_ADDR, default 8'hFF, meaning the address decoded as the memory-mapped output port.
REQ-003 SHALL have parameter RELEASE_CYCLES, default 3, meaning the number of clk cycles cpu_reset is held after loading completes.

Interface
REQ-004 clk  input  1  single system clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 addr_bus  input  8  CPU memory address.
REQ-007 c_ri  input  1  CPU write request (RAM in).
REQ-008 c_ro  input  1  CPU read request (RAM out).
REQ-009 mem_clk  input  1  CPU memory-phase strobe, sampled as level on clk.
REQ-010 bus  inout  8  shared CPU data bus, high-Z unless driving a read.
REQ-011 load_valid  input  1  loader byte valid.
REQ-012 load_data  input  8  loader byte.
REQ-013 load_last  input  1  marks final loader byte, qualified by load_valid.
REQ-014 load_ready  output  1  memory_unit accepts a loader byte this cycle.
REQ-015 cpu_reset  output  1  reset to the CPU, high until RUN.
REQ-016 out_data  output  8  last byte written to OUT_ADDR.
REQ-017 out_strobe  output  1  one-clk pulse per OUT_ADDR write.

Function
REQ-018 SHALL contain 256 x 8 RAM indexed by addr_bus, 8-bit pointer ptr, and a FSM with states LOAD, RELEASE, RUN.
REQ-019 LOAD: load_ready=1, cpu_reset=1, bus high-Z, c_ri/c_ro/mem_clk ignored.
REQ-020 LOAD: on load_valid & load_ready, SHALL write mem[ptr] <= load_data and increment ptr.
REQ-021 LOAD -> RELEASE on an accepted byte with load_last=1, or on an accepted byte at ptr=8'hFF (no wrap; byte 256 ends load regardless of load_last).
REQ-022 RELEASE: load_ready=0, cpu_reset=1, counter runs RELEASE_CYCLES clks, then -> RUN.
REQ-023 RUN: cpu_reset=0, load_ready=0, load inputs ignored; RUN persists until reset.
REQ-024 RUN write: SHALL detect the rising level of mem_clk (mem_clk=1, registered mem_clk_q=0) and perform exactly one write per mem_clk pulse when c_ri=1 at that edge.
REQ-025 Write to addr != OUT_ADDR: mem[addr_bus] <= bus.
REQ-026 Write to addr = OUT_ADDR: out_data <= bus, out_strobe=1 for the following clk cycle, RAM not modified.
REQ-027 RUN read: while c_ro=1 and c_ri=0, bus SHALL be driven combinationally with mem[addr_bus], or with out_data when addr_bus=OUT_ADDR; otherwise high-Z.
REQ-028 c_ri and c_ro both high: write performed on the mem_clk edge, bus not driven.
REQ-029 mem_clk held high several clks: only one write.

Reset
REQ-030 reset SHALL asynchronously force: state=LOAD (RUN if LOAD_ENABLE=0), ptr=0, release counter=0, mem_clk_q=0, out_data=8'h00, out_strobe=0, cpu_reset=1 (0 if LOAD_ENABLE=0), load_ready=0 while reset is high, bus high-Z.
REQ-031 RAM contents SHALL NOT be cleared by reset; reset mid-load restarts loading at ptr=0.

Verification
REQ-032 Load bytes 8'h10,8'h20,8'h30 (last on third) -> mem[0..2]=10,20,30; cpu_reset falls exactly RELEASE_CYCLES+1 clks after third accept.
REQ-033 Stream 256 bytes, load_last=0 -> all 256 stored, ptr wraps to 0, FSM in RELEASE, byte 257 not accepted (load_ready=0).
REQ-034 RUN, addr=8'h05, c_ri=1, bus=8'hA5, mem_clk high 3 clks -> one write; then c_ro=1 at addr 5 -> bus reads 8'hA5.
REQ-035 RUN, write 8'h42 to addr 8'hFF -> out_data=8'h42, out_strobe high exactly one clk, mem[8'hFF] unchanged.
REQ-036 Assert reset after 2 loaded bytes -> cpu_reset=1, load restarts at ptr=0, previously loaded bytes retained until overwritten.
REQ-037 Any cycle in LOAD/RELEASE with c_ro=1 -> bus stays high-Z.
